riscv_multi_cycle_controller: RTL and testbench

Parametrised multi-cycle control unit for the RV32I core, the successor to the single-cycle controller. Takes opcode/f3/f7/zero from the datapath and sequences each instruction through a state machine over several cycles. Memory accesses use one shared memory port with a req/ready handshake, so variable-latency memory is supported. Adds a retired-instruction counter, an optional memory-stall timeout and a sticky fault state.

---
 rtl/riscv_multi_cycle_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_riscv_multi_cycle_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multi_cycle_controller.sv
// Multi-cycle RV32I control unit: sequences each instruction through an FSM,
// handshakes with a shared variable-latency memory port and tracks retirement/faults.
module riscv_multi_cycle_controller #(
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 0,
    parameter int STALL_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_update,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_function,
    output logic [2:0]       imm_src,
    output logic [1:0]       result_src,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE,
        EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, LUI, FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam bit               TIMEOUT_EN = (STALL_LIMIT > 0);
    localparam logic [STALL_W-1:0] STALL_LAST =
        STALL_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);

    state_t             state, next_state;
    logic [1:0]         fault_q, next_fault;
    logic [CNT_W-1:0]   instret_q;
    logic [STALL_W-1:0] stall_cnt;

    logic       mem_req_d, mem_write_d, adr_src_d, ir_write_d, pc_update_d, reg_write_d;
    logic [1:0] alu_src_a_d, alu_src_b_d, result_src_d;
    logic [2:0] alu_function_d, imm_src_d;
    logic [2:0] alu_op;
    logic       alu_ok;
    logic       stall_hit;

    // The shared ALU decode; f7 only qualifies the operation for register-register ops.
    always_comb begin
        alu_op = ALU_ADD;
        alu_ok = 1'b1;
        case (f3)
            3'b000: begin
                alu_op = (state == EXEC_R && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                alu_ok = (state != EXEC_R) || (f7 == F7_BASE) || (f7 == F7_ALT);
            end
            3'b010: begin alu_op = ALU_SLT; alu_ok = (state != EXEC_R) || (f7 == F7_BASE); end
            3'b100: begin alu_op = ALU_XOR; alu_ok = (state != EXEC_R) || (f7 == F7_BASE); end
            3'b110: begin alu_op = ALU_OR;  alu_ok = (state != EXEC_R) || (f7 == F7_BASE); end
            3'b111: begin alu_op = ALU_AND; alu_ok = (state != EXEC_R) || (f7 == F7_BASE); end
            default: alu_ok = 1'b0;
        endcase
    end

    assign stall_hit = TIMEOUT_EN && (stall_cnt == STALL_LAST);

    always_comb begin
        mem_req_d      = 1'b0;
        mem_write_d    = 1'b0;
        adr_src_d      = 1'b0;
        ir_write_d     = 1'b0;
        pc_update_d    = 1'b0;
        reg_write_d    = 1'b0;
        alu_src_a_d    = 2'b00;
        alu_src_b_d    = 2'b00;
        alu_function_d = ALU_ADD;
        imm_src_d      = 3'b000;
        result_src_d   = 2'b00;
        next_state     = state;
        next_fault     = fault_q;
        case (state)
            FETCH: begin
                mem_req_d    = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
                if (!mem_ready && stall_hit) begin
                    next_state = FAULT;
                    next_fault = FAULT_TIMEOUT;
                end else if (mem_ready) begin
                    ir_write_d  = 1'b1;
                    pc_update_d = 1'b1;
                    next_state  = DECODE;
                end
            end
            DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
                imm_src_d   = 3'b010;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEM_ADR;
                    OP_R:              next_state = EXEC_R;
                    OP_I:              next_state = EXEC_I;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_LUI:            next_state = LUI;
                    default: begin
                        next_state = FAULT;
                        next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end
            MEM_ADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                imm_src_d   = (opcode == OP_LOAD) ? 3'b000 : 3'b001;
                next_state  = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ, MEM_WRITE: begin
                mem_req_d   = 1'b1;
                mem_write_d = (state == MEM_WRITE);
                adr_src_d   = 1'b1;
                if (!mem_ready && stall_hit) begin
                    next_state = FAULT;
                    next_fault = FAULT_TIMEOUT;
                end else if (mem_ready) begin
                    next_state = (state == MEM_READ) ? MEM_WB : FETCH;
                end
            end
            MEM_WB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
                next_state   = FETCH;
            end
            EXEC_R, EXEC_I: begin
                alu_src_a_d    = 2'b10;
                alu_src_b_d    = (state == EXEC_I) ? 2'b01 : 2'b00;
                alu_function_d = alu_op;
                if (alu_ok) begin
                    next_state = ALU_WB;
                end else begin
                    next_state = FAULT;
                    next_fault = FAULT_ILLEGAL;
                end
            end
            ALU_WB: begin
                reg_write_d = 1'b1;
                next_state  = FETCH;
            end
            BRANCH: begin
                alu_src_a_d    = 2'b10;
                alu_function_d = ALU_SUB;
                case (f3)
                    3'b000: begin pc_update_d = zero;  next_state = FETCH; end
                    3'b001: begin pc_update_d = !zero; next_state = FETCH; end
                    default: begin
                        next_state = FAULT;
                        next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end
            JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_update_d = 1'b1;
                next_state  = ALU_WB;
            end
            LUI: begin
                alu_src_a_d = 2'b11;
                alu_src_b_d = 2'b01;
                imm_src_d   = 3'b100;
                next_state  = ALU_WB;
            end
            default: next_state = FAULT;
        endcase
    end

    // Retirement is any return to FETCH from a different state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            fault_q   <= FAULT_NONE;
            instret_q <= '0;
            stall_cnt <= '0;
        end else begin
            state   <= next_state;
            fault_q <= next_fault;
            if (next_state == FETCH && state != FETCH)
                instret_q <= instret_q + CNT_W'(1);
            stall_cnt <= (mem_req_d && !mem_ready) ? stall_cnt + STALL_W'(1) : '0;
        end
    end

    assign mem_req      = mem_req_d   & ~reset;
    assign mem_write    = mem_write_d & ~reset;
    assign adr_src      = adr_src_d   & ~reset;
    assign ir_write     = ir_write_d  & ~reset;
    assign pc_update    = pc_update_d & ~reset;
    assign reg_write    = reg_write_d & ~reset;
    assign alu_src_a    = reset ? 2'b00 : alu_src_a_d;
    assign alu_src_b    = reset ? 2'b00 : alu_src_b_d;
    assign alu_function = reset ? 3'b000 : alu_function_d;
    assign imm_src      = reset ? 3'b000 : imm_src_d;
    assign result_src   = reset ? 2'b00 : result_src_d;
    assign fault        = reset ? FAULT_NONE : fault_q;
    assign instret      = reset ? '0 : instret_q;

endmodule

// File: tb/tb_riscv_multi_cycle_controller.sv
// Self-checking bench: an instruction-level model expands each instruction into its
// expected per-cycle control vector; one compare process checks the DUT every cycle.
module tb_riscv_multi_cycle_controller;

    localparam int CW = 4;
    localparam int SL = 4;
    localparam int SW = 8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, SLT = 3'd4, XOR_ = 3'd5;

    typedef struct packed {
        logic       req, wr, adr, ir, pc, rw;
        logic [1:0] a, b;
        logic [2:0] fn, imm;
        logic [1:0] rs;
    } ctrl_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    f3 = '0;
    logic [6:0]    f7 = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_write, adr_src, ir_write, pc_update, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, result_src, fault;
    logic [2:0]    alu_function, imm_src;
    logic [CW-1:0] instret;

    riscv_multi_cycle_controller #(.CNT_W(CW), .STALL_LIMIT(SL), .STALL_W(SW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .f3(f3), .f7(f7), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_update(pc_update), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_function(alu_function),
        .imm_src(imm_src), .result_src(result_src), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    bit    check_en = 1'b0;
    string step_name = "idle";
    ctrl_t exp_ctrl = '0;
    int    exp_fault = 0;
    int    exp_instret = 0;
    int    m_fault = 0;
    int    m_instret = 0;
    ctrl_t act_ctrl;

    assign act_ctrl = {mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
                       alu_src_a, alu_src_b, alu_function, imm_src, result_src};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput({step_name, " ctrl"}, 32'(act_ctrl), 32'(exp_ctrl));
            checkOutput({step_name, " fault"}, 32'(fault), exp_fault);
            checkOutput({step_name, " instret"}, 32'(instret), exp_instret);
        end
    end

    function automatic ctrl_t mk(input logic req, wr, adr, ir, pc, rw,
                                 input logic [1:0] a, b, input logic [2:0] fn, imm,
                                 input logic [1:0] rs);
        return {req, wr, adr, ir, pc, rw, a, b, fn, imm, rs};
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Returns {legal, alu_function} from the f3/f7 operation table.
    function automatic logic [3:0] alu_model(input logic is_r, input logic [2:0] f, input logic [6:0] g);
        logic       ok;
        logic [2:0] fn;
        ok = 1'b1;
        fn = ADD;
        case (f)
            3'b000: begin fn = (is_r && g == 7'h20) ? SUB : ADD; ok = !is_r || g == 7'h00 || g == 7'h20; end
            3'b010: begin fn = SLT;  ok = !is_r || g == 7'h00; end
            3'b100: begin fn = XOR_; ok = !is_r || g == 7'h00; end
            3'b110: begin fn = OR_;  ok = !is_r || g == 7'h00; end
            3'b111: begin fn = AND_; ok = !is_r || g == 7'h00; end
            default: ok = 1'b0;
        endcase
        return {ok, fn};
    endfunction

    // One clock of expectation: the outputs seen before the next edge must equal c.
    task automatic cyc(input string nm, input ctrl_t c, input logic rdy);
        step_name   = nm;
        exp_ctrl    = c;
        exp_fault   = m_fault;
        exp_instret = m_instret;
        mem_ready   = rdy;
        check_en    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        m_instret = (m_instret + 1) % (1 << CW);
    endtask

    task automatic memPhase(input string nm, input ctrl_t c_wait, input ctrl_t c_done,
                            input int w, output bit ok);
        ok = 1'b0;
        for (int i = 1; i <= w; i++) begin
            cyc({nm, " wait"}, c_wait, 1'b0);
            if (SL > 0 && i == SL) begin
                m_fault = 2;
                return;
            end
        end
        cyc(nm, c_done, 1'b1);
        ok = 1'b1;
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        m_fault   = 0;
        m_instret = 0;
        cyc("reset", '0, rnd());
        reset = 1'b0;
    endtask

    task automatic startInstr(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                              input logic z, input int fw, output bit ok);
        opcode = op;
        f3     = fn3;
        f7     = fn7;
        zero   = z;
        memPhase("fetch", mk(1,0,0,0,0,0, 2'b00,2'b10, ADD,3'b000, 2'b10),
                          mk(1,0,0,1,1,0, 2'b00,2'b10, ADD,3'b000, 2'b10), fw, ok);
        if (ok) cyc("decode", mk(0,0,0,0,0,0, 2'b01,2'b01, ADD,3'b010, 2'b00), rnd());
    endtask

    // Runs one whole instruction through the model, driving inputs as it goes.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                                 input logic z, input int fw, input int mw);
        bit         ok;
        logic [3:0] af;
        logic       pc;
        if (m_fault != 0) begin
            cyc("fault hold", '0, rnd());
            return;
        end
        startInstr(op, fn3, fn7, z, fw, ok);
        if (!ok) return;
        case (op)
            OP_LOAD, OP_STORE: begin
                cyc("mem_adr", mk(0,0,0,0,0,0, 2'b10,2'b01, ADD, (op == OP_LOAD) ? 3'b000 : 3'b001, 2'b00), rnd());
                if (op == OP_LOAD) begin
                    memPhase("mem_read", mk(1,0,1,0,0,0, 2'b00,2'b00, ADD,3'b000, 2'b00),
                                         mk(1,0,1,0,0,0, 2'b00,2'b00, ADD,3'b000, 2'b00), mw, ok);
                    if (!ok) return;
                    cyc("mem_wb", mk(0,0,0,0,0,1, 2'b00,2'b00, ADD,3'b000, 2'b01), rnd());
                end else begin
                    memPhase("mem_write", mk(1,1,1,0,0,0, 2'b00,2'b00, ADD,3'b000, 2'b00),
                                          mk(1,1,1,0,0,0, 2'b00,2'b00, ADD,3'b000, 2'b00), mw, ok);
                    if (!ok) return;
                end
                retire();
            end
            OP_R, OP_I: begin
                af = alu_model(op == OP_R, fn3, fn7);
                cyc("exec", mk(0,0,0,0,0,0, 2'b10, (op == OP_R) ? 2'b00 : 2'b01, af[2:0], 3'b000, 2'b00), rnd());
                if (!af[3]) begin
                    m_fault = 1;
                    return;
                end
                cyc("alu_wb", mk(0,0,0,0,0,1, 2'b00,2'b00, ADD,3'b000, 2'b00), rnd());
                retire();
            end
            OP_BRANCH: begin
                pc = (fn3 == 3'b000) ? z : (fn3 == 3'b001) ? !z : 1'b0;
                cyc("branch", mk(0,0,0,0,pc,0, 2'b10,2'b00, SUB,3'b000, 2'b00), rnd());
                if (fn3 > 3'b001) m_fault = 1;
                else              retire();
            end
            OP_JAL: begin
                cyc("jal", mk(0,0,0,0,1,0, 2'b01,2'b10, ADD,3'b000, 2'b00), rnd());
                cyc("alu_wb", mk(0,0,0,0,0,1, 2'b00,2'b00, ADD,3'b000, 2'b00), rnd());
                retire();
            end
            OP_LUI: begin
                cyc("lui", mk(0,0,0,0,0,0, 2'b11,2'b01, ADD,3'b100, 2'b00), rnd());
                cyc("alu_wb", mk(0,0,0,0,0,1, 2'b00,2'b00, ADD,3'b000, 2'b00), rnd());
                retire();
            end
            default: m_fault = 1;
        endcase
    endtask

    logic [6:0] ops [8] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_LUI, OP_JALR};

    initial begin
        bit         ok;
        int         k;
        logic [6:0] op;
        logic [6:0] g;
        @(posedge clk);
        #1;
        applyReset();
        checkOutput("reset instret", 32'(instret), 0);
        checkOutput("reset fault", 32'(fault), 0);

        // add x3,x1,x2 (0x002081B3)
        applyStimulus(OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
        checkOutput("add instret", 32'(instret), 1);

        applyStimulus(OP_LOAD, 3'b010, 7'h00, 1'b0, 3, 3);
        checkOutput("lw instret", 32'(instret), 2);

        applyStimulus(OP_BRANCH, 3'b000, 7'h00, 1'b1, 0, 0);
        applyStimulus(OP_BRANCH, 3'b000, 7'h00, 1'b0, 0, 0);
        applyStimulus(OP_BRANCH, 3'b001, 7'h00, 1'b0, 1, 0);
        applyStimulus(OP_STORE, 3'b010, 7'h00, 1'b0, 0, 2);
        applyStimulus(OP_JAL, 3'b000, 7'h00, 1'b0, 0, 0);
        applyStimulus(OP_LUI, 3'b000, 7'h00, 1'b0, 0, 0);
        applyStimulus(OP_R, 3'b000, 7'h20, 1'b0, 0, 0);
        applyStimulus(OP_BRANCH, 3'b100, 7'h00, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
        checkOutput("bad branch fault", 32'(fault), 1);
        applyReset();

        applyStimulus(OP_JALR, 3'b000, 7'h00, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
        checkOutput("jalr fault", 32'(fault), 1);
        applyReset();
        checkOutput("post-fault instret", 32'(instret), 0);

        applyStimulus(OP_R, 3'b000, 7'h00, 1'b0, 6, 0);
        applyStimulus(OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
        checkOutput("stall fault", 32'(fault), 2);
        applyReset();

        for (int i = 0; i < 17; i++) applyStimulus(OP_I, 3'b000, 7'h00, 1'b0, 0, 0);
        checkOutput("instret wrap", 32'(instret), 1);

        // Reset lands while the store sits in its address phase.
        applyReset();
        startInstr(OP_STORE, 3'b010, 7'h00, 1'b0, 0, ok);
        applyReset();
        applyStimulus(OP_STORE, 3'b010, 7'h00, 1'b0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 8);
            op = (k == 8) ? 7'($urandom) : ops[k];
            k  = $urandom_range(0, 3);
            g  = (k == 0) ? 7'($urandom) : (k == 1) ? 7'h20 : 7'h00;
            applyStimulus(op, 3'($urandom), g, rnd(),
                          ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 3),
                          ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 3));
            if (m_fault != 0) begin
                applyStimulus(OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
                applyStimulus(OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
                applyReset();
            end
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
